// File: rtl/shift_arbiter_if.sv
// Request/response/shifter bundle between the two shift requesters, the
// shared barrel shifter and shift_arbiter. The slave modport is the arbiter.
interface shift_arbiter_if #(
  parameter int CNT_W = 16
);
  logic              i_req0_valid;
  logic              o_req0_ready;
  logic [31:0]       i_req0_data;
  logic [4:0]        i_req0_amt;
  logic [1:0]        i_req0_op;
  logic              i_req1_valid;
  logic              o_req1_ready;
  logic [31:0]       i_req1_data;
  logic [4:0]        i_req1_amt;
  logic [1:0]        i_req1_op;
  logic              o_rsp0_valid;
  logic              i_rsp0_ready;
  logic              o_rsp1_valid;
  logic              i_rsp1_ready;
  logic [31:0]       o_rsp_data;
  logic [31:0]       o_sh_in;
  logic [4:0]        o_sh_amt;
  logic              o_sh_dir;
  logic              o_sh_arith;
  logic [31:0]       i_sh_out;
  logic [CNT_W-1:0]  o_conflicts;

  modport slave (
    input  i_req0_valid, i_req0_data, i_req0_amt, i_req0_op,
    input  i_req1_valid, i_req1_data, i_req1_amt, i_req1_op,
    input  i_rsp0_ready, i_rsp1_ready, i_sh_out,
    output o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid,
    output o_rsp_data, o_sh_in, o_sh_amt, o_sh_dir, o_sh_arith, o_conflicts
  );

  modport master (
    output i_req0_valid, i_req0_data, i_req0_amt, i_req0_op,
    output i_req1_valid, i_req1_data, i_req1_amt, i_req1_op,
    output i_rsp0_ready, i_rsp1_ready, i_sh_out,
    input  o_req0_ready, o_req1_ready, o_rsp0_valid, o_rsp1_valid,
    input  o_rsp_data, o_sh_in, o_sh_amt, o_sh_dir, o_sh_arith, o_conflicts
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one combinational barrel shifter between the
// ALU shift path (port 0) and the load/store alignment path (port 1).
module shift_arbiter #(
  parameter int CNT_W      = 16,
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  shift_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, FULL0, FULL1} slot_e;

  slot_e            state;
  logic             ptr;        // 1: port 1 wins a tie
  logic [31:0]      rsp_q;
  logic [CNT_W-1:0] cnt_q;

  logic       slot_free, both, gnt0, gnt1;
  logic [1:0] sel_op;

  always_comb begin
    slot_free = (state == EMPTY)
              | ((state == FULL0) & bus.i_rsp0_ready)
              | ((state == FULL1) & bus.i_rsp1_ready);
    both = bus.i_req0_valid & bus.i_req1_valid;
    gnt0 = i_rst_n & slot_free & bus.i_req0_valid & (~bus.i_req1_valid | ~ptr);
    gnt1 = i_rst_n & slot_free & bus.i_req1_valid & (~bus.i_req0_valid | ptr);
  end

  assign bus.o_req0_ready = gnt0;
  assign bus.o_req1_ready = gnt1;

  // Idle cycles present port 0's fields so the shifter inputs do not toggle.
  always_comb begin
    bus.o_sh_in    = '0;
    bus.o_sh_amt   = '0;
    bus.o_sh_dir   = 1'b0;
    bus.o_sh_arith = 1'b0;
    sel_op         = gnt1 ? bus.i_req1_op : bus.i_req0_op;
    if (i_rst_n) begin
      bus.o_sh_in    = gnt1 ? bus.i_req1_data : bus.i_req0_data;
      bus.o_sh_amt   = gnt1 ? bus.i_req1_amt  : bus.i_req0_amt;
      bus.o_sh_dir   = (sel_op != 2'b01) && (sel_op != 2'b10);
      bus.o_sh_arith = (sel_op == 2'b10);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= EMPTY;
      ptr   <= PRIO_RESET;
      rsp_q <= '0;
      cnt_q <= '0;
    end else if (gnt0 | gnt1) begin
      state <= gnt1 ? FULL1 : FULL0;
      rsp_q <= bus.i_sh_out;
      ptr   <= gnt0;
      if (both && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + CNT_W'(1);
    end else if (slot_free) begin
      state <= EMPTY;
    end
  end

  assign bus.o_rsp0_valid = (state == FULL0);
  assign bus.o_rsp1_valid = (state == FULL1);
  assign bus.o_rsp_data   = rsp_q;
  assign bus.o_conflicts  = cnt_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus a randomized
// run against a behavioural arbitration/shift model.
module tb_shift_arbiter;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  shift_arbiter_if #(.CNT_W(CNT_W)) bus();
  shift_arbiter #(.CNT_W(CNT_W), .PRIO_RESET(1'b0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // Shared barrel shifter living outside the arbiter.
  logic signed [31:0] sh_sra;
  assign sh_sra = $signed(bus.o_sh_in) >>> bus.o_sh_amt;
  assign bus.i_sh_out = bus.o_sh_dir ? (bus.o_sh_in << bus.o_sh_amt)
                      : bus.o_sh_arith ? sh_sra : (bus.o_sh_in >> bus.o_sh_amt);

  // Reference shift semantics: SRA built as logical shift plus sign fill.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a,
                                            input logic [1:0] op);
    logic [31:0] r, ones;
    ones = 32'hFFFF_FFFF;
    case (op)
      2'b01: r = d >> a;
      2'b10: begin
        r = d >> a;
        if (d[31]) r = r | ~(ones >> a);
      end
      default: r = d << a;
    endcase
    return r;
  endfunction

  // Behavioural model: owner -1 = empty, else owning port.
  int          m_own, m_ptr, m_cnt;
  logic [31:0] m_data;

  function automatic bit m_free();
    return (m_own == -1) || (m_own == 0 && bus.i_rsp0_ready) || (m_own == 1 && bus.i_rsp1_ready);
  endfunction

  function automatic int m_grant();
    if (!m_free()) return -1;
    if (bus.i_req0_valid && bus.i_req1_valid) return m_ptr;
    if (bus.i_req0_valid) return 0;
    if (bus.i_req1_valid) return 1;
    return -1;
  endfunction

  task automatic m_edge(input int g, input bit free, input bit both);
    if (g == 0) m_data = ref_shift(bus.i_req0_data, bus.i_req0_amt, bus.i_req0_op);
    if (g == 1) m_data = ref_shift(bus.i_req1_data, bus.i_req1_amt, bus.i_req1_op);
    if (g >= 0) begin
      m_own = g;
      m_ptr = 1 - g;
      if (both && m_cnt < CMAX) m_cnt++;
    end else if (free) begin
      m_own = -1;
    end
  endtask

  task automatic m_reset();
    m_own = -1; m_ptr = 0; m_cnt = 0; m_data = '0;
  endtask

  task automatic set_req(input int p, input bit v, input logic [31:0] d,
                         input logic [4:0] a, input logic [1:0] op);
    if (p == 0) begin
      bus.i_req0_valid = v; bus.i_req0_data = d; bus.i_req0_amt = a; bus.i_req0_op = op;
    end else begin
      bus.i_req1_valid = v; bus.i_req1_data = d; bus.i_req1_amt = a; bus.i_req1_op = op;
    end
  endtask

  task automatic idle();
    set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
    set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
    bus.i_rsp0_ready = 1'b1;
    bus.i_rsp1_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, 32'h1234_5678, 5'd3, 2'b01);
    set_req(1, 1'b1, 32'h0000_00F0, 5'd4, 2'b10);
    bus.i_rsp0_ready = 1'b1; bus.i_rsp1_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.o_req0_ready !== 1'b0 || bus.o_req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b want 00", bus.o_req0_ready, bus.o_req1_ready); end
    checks++; if (bus.o_rsp0_valid !== 1'b0 || bus.o_rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid: got %b%b want 00", bus.o_rsp0_valid, bus.o_rsp1_valid); end
    checks++; if (bus.o_rsp_data !== 32'h0) begin
      errors++; $display("FAIL reset_rsp_data: got %h want 0", bus.o_rsp_data); end
    checks++; if (bus.o_conflicts !== '0) begin
      errors++; $display("FAIL reset_conflicts: got %0d want 0", bus.o_conflicts); end
    checks++; if (bus.o_sh_in !== 32'h0 || bus.o_sh_amt !== 5'd0 || bus.o_sh_dir !== 1'b0 || bus.o_sh_arith !== 1'b0) begin
      errors++; $display("FAIL reset_sh: got in=%h amt=%0d dir=%b ar=%b want zeros",
                         bus.o_sh_in, bus.o_sh_amt, bus.o_sh_dir, bus.o_sh_arith); end
    idle();
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b1, 32'h8000_0001, 5'd4, 2'b10);
    #1;
    checks++; if (bus.o_req0_ready !== 1'b1) begin
      errors++; $display("FAIL single_ready0: got %b want 1", bus.o_req0_ready); end
    checks++; if (bus.o_sh_dir !== 1'b0 || bus.o_sh_arith !== 1'b1) begin
      errors++; $display("FAIL single_decode: got dir=%b ar=%b want 0 1", bus.o_sh_dir, bus.o_sh_arith); end
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
    checks++; if (bus.o_rsp0_valid !== 1'b1 || bus.o_rsp_data !== 32'hF800_0000) begin
      errors++; $display("FAIL single_rsp: got v=%b d=%h want 1 f8000000", bus.o_rsp0_valid, bus.o_rsp_data); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [31:0] want;
    do_reset();
    set_req(0, 1'b1, 32'h0000_0001, 5'd31, 2'b00);
    set_req(1, 1'b1, 32'h0000_00F0, 5'd4, 2'b01);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.o_req0_ready !== ((c % 2) == 0) || bus.o_req1_ready !== ((c % 2) == 1)) begin
        errors++; $display("FAIL contend_grant c%0d: got %b%b want port %0d", c,
                           bus.o_req1_ready, bus.o_req0_ready, c % 2); end
      @(posedge clk); #1;
      want = ((c % 2) == 0) ? 32'h8000_0000 : 32'h0000_000F;
      checks++; if (bus.o_rsp_data !== want || bus.o_conflicts !== CNT_W'(c + 1)) begin
        errors++; $display("FAIL contend_rsp c%0d: got d=%h cnt=%0d want d=%h cnt=%0d", c,
                           bus.o_rsp_data, bus.o_conflicts, want, c + 1); end
      @(negedge clk);
    end
    idle();
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    do_reset();
    set_req(1, 1'b1, 32'h0000_ABCD, 5'd8, 2'b00);
    bus.i_rsp1_ready = 1'b0;
    @(posedge clk); #1;
    held = bus.o_rsp_data;
    checks++; if (bus.o_rsp1_valid !== 1'b1 || held !== 32'h00AB_CD00) begin
      errors++; $display("FAIL bp_fill: got v=%b d=%h want 1 00abcd00", bus.o_rsp1_valid, held); end
    @(negedge clk);
    set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
    set_req(0, 1'b1, 32'h0000_0F00, 5'd8, 2'b01);
    bus.i_rsp0_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (bus.o_req0_ready !== 1'b0) begin
        errors++; $display("FAIL bp_stall_ready c%0d: got %b want 0", c, bus.o_req0_ready); end
      @(posedge clk); #1;
      checks++; if (bus.o_rsp_data !== held || bus.o_rsp1_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold c%0d: got v=%b d=%h want 1 %h", c, bus.o_rsp1_valid, bus.o_rsp_data, held); end
      @(negedge clk);
    end
    bus.i_rsp1_ready = 1'b1;
    #1;
    checks++; if (bus.o_req0_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b want 1", bus.o_req0_ready); end
    @(posedge clk); #1;
    checks++; if (bus.o_rsp0_valid !== 1'b1 || bus.o_rsp1_valid !== 1'b0 || bus.o_rsp_data !== 32'h0000_000F) begin
      errors++; $display("FAIL bp_release_rsp: got v0=%b v1=%b d=%h want 1 0 0000000f",
                         bus.o_rsp0_valid, bus.o_rsp1_valid, bus.o_rsp_data); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reserved_and_zero();
    logic [31:0] d;
    logic [31:0] want;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      d = (c == 0) ? 32'h3 : $urandom;
      set_req(c % 2, 1'b1, d, (c == 0) ? 5'd1 : 5'd0, (c == 0) ? 2'b11 : 2'(c - 1));
      want = (c == 0) ? 32'h6 : d;
      @(posedge clk); #1;
      checks++; if (bus.o_rsp_data !== want) begin
        errors++; $display("FAIL op_case c%0d: got %h want %h", c, bus.o_rsp_data, want); end
      @(negedge clk);
      idle();
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(1, 1'b1, 32'h1, 5'd1, 2'b00);
    set_req(0, 1'b1, 32'h1, 5'd2, 2'b00);
    bus.i_rsp1_ready = 1'b0;
    @(posedge clk); #1;       // port 0 wins the tie, pointer now favours port 1
    @(negedge clk);
    set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
    @(posedge clk); #1;       // port 1 granted, held with ready low
    checks++; if (bus.o_rsp1_valid !== 1'b1 || bus.o_conflicts !== CNT_W'(1)) begin
      errors++; $display("FAIL areset_pre: got v1=%b cnt=%0d want 1 1", bus.o_rsp1_valid, bus.o_conflicts); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.o_rsp1_valid !== 1'b0 || bus.o_conflicts !== '0 || bus.o_rsp_data !== 32'h0) begin
      errors++; $display("FAIL areset_drop: got v1=%b cnt=%0d d=%h want 0 0 0",
                         bus.o_rsp1_valid, bus.o_conflicts, bus.o_rsp_data); end
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    m_reset();
    // Leave pointer at port 1, reset again, and confirm the tie goes back to port 0.
    set_req(0, 1'b1, 32'h5, 5'd0, 2'b00);
    set_req(1, 1'b1, 32'h6, 5'd0, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus.o_req0_ready !== 1'b1 || bus.o_req1_ready !== 1'b0 || bus.o_rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL areset_ptr: got r0=%b r1=%b v0=%b want 1 0 0",
                         bus.o_req0_ready, bus.o_req1_ready, bus.o_rsp0_valid); end
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    set_req(0, 1'b1, 32'h1, 5'd1, 2'b00);
    set_req(1, 1'b1, 32'h2, 5'd1, 2'b01);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (bus.o_conflicts !== CNT_W'(CMAX)) begin
      errors++; $display("FAIL saturate: got %0d want %0d", bus.o_conflicts, CMAX); end
    @(posedge clk); #1;
    checks++; if (bus.o_conflicts !== CNT_W'(CMAX)) begin
      errors++; $display("FAIL saturate_hold: got %0d want %0d", bus.o_conflicts, CMAX); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_random();
    int  g, prev_g;
    bit  free, both;
    logic [31:0] wd;
    logic [4:0]  wa;
    do_reset();
    prev_g = -1;
    for (int c = 0; c < 400; c++) begin
      // A pending request keeps its fields until it is accepted.
      if (!(bus.i_req0_valid && prev_g != 0))
        set_req(0, $urandom_range(0, 99) < 60, $urandom, 5'($urandom), 2'($urandom));
      if (!(bus.i_req1_valid && prev_g != 1))
        set_req(1, $urandom_range(0, 99) < 60, $urandom, 5'($urandom), 2'($urandom));
      bus.i_rsp0_ready = $urandom_range(0, 99) < 70;
      bus.i_rsp1_ready = $urandom_range(0, 99) < 70;
      #1;
      g = m_grant(); free = m_free(); both = bus.i_req0_valid && bus.i_req1_valid;
      checks++; if (bus.o_req0_ready !== (g == 0) || bus.o_req1_ready !== (g == 1)) begin
        errors++; $display("FAIL rand_grant c%0d: got %b%b want port %0d", c,
                           bus.o_req1_ready, bus.o_req0_ready, g); end
      if (g >= 0) begin
        wd = (g == 0) ? bus.i_req0_data : bus.i_req1_data;
        wa = (g == 0) ? bus.i_req0_amt : bus.i_req1_amt;
        checks++; if (bus.o_sh_in !== wd || bus.o_sh_amt !== wa) begin
          errors++; $display("FAIL rand_sh c%0d: got %h/%0d want %h/%0d", c, bus.o_sh_in, bus.o_sh_amt, wd, wa); end
      end
      @(posedge clk); #1;
      m_edge(g, free, both);
      prev_g = g;
      checks++; if (bus.o_rsp0_valid !== (m_own == 0) || bus.o_rsp1_valid !== (m_own == 1)
                    || bus.o_conflicts !== CNT_W'(m_cnt)) begin
        errors++; $display("FAIL rand_state c%0d: got v0=%b v1=%b cnt=%0d want own=%0d cnt=%0d", c,
                           bus.o_rsp0_valid, bus.o_rsp1_valid, bus.o_conflicts, m_own, m_cnt); end
      if (m_own >= 0) begin
        checks++; if (bus.o_rsp_data !== m_data) begin
          errors++; $display("FAIL rand_data c%0d: got %h want %h", c, bus.o_rsp_data, m_data); end
      end
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    idle();
    m_reset();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_reserved_and_zero();
    test_async_reset();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
